// File: rtl/amstrad_mem_arbiter.sv
// Serialises CPU byte accesses and gate-array word fetches onto one byte-wide SDRAM port.
// Define MEM_ARB_ROM_WP_EN to block CPU writes into ROM space (cpu_addr[22]=1).
module amstrad_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_done,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_done,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        err
);
    typedef enum logic [1:0] {IDLE = 2'd0, CPU_ACC = 2'd1, VID_LO = 2'd2, VID_HI = 2'd3} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pend_cpu_q, pend_cpu_d, pend_vid_q, pend_vid_d;
    logic        cpu_we_lat_q, cpu_we_lat_d;
    logic [22:0] cpu_addr_lat_q, cpu_addr_lat_d;
    logic [7:0]  cpu_dat_lat_q, cpu_dat_lat_d;
    logic [14:0] vid_addr_lat_q, vid_addr_lat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        cpu_done_q, cpu_done_d, vid_done_q, vid_done_d;
    logic [15:0] vid_data_q, vid_data_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_oe_q, mem_oe_d, mem_we_q, mem_we_d, err_q, err_d;
    logic        waiting_s, timeout_s, ack_s, rom_wp_s, cpu_clr_s, vid_clr_s;
    logic [7:0]  rd_data_s;

    // Next-state, pending-latch and output computation.
    always_comb begin
        state_d        = state_q;
        pend_cpu_d     = pend_cpu_q;
        pend_vid_d     = pend_vid_q;
        cpu_we_lat_d   = cpu_we_lat_q;
        cpu_addr_lat_d = cpu_addr_lat_q;
        cpu_dat_lat_d  = cpu_dat_lat_q;
        vid_addr_lat_d = vid_addr_lat_q;
        tmo_d          = tmo_q;
        cpu_din_d      = cpu_din_q;
        cpu_done_d     = 1'b0;
        vid_done_d     = 1'b0;
        vid_data_d     = vid_data_q;
        mem_addr_d     = mem_addr_q;
        mem_dout_d     = mem_dout_q;
        mem_oe_d       = mem_oe_q;
        mem_we_d       = mem_we_q;
        err_d          = err_q;
        cpu_clr_s      = 1'b0;
        vid_clr_s      = 1'b0;

        waiting_s = mem_oe_q | mem_we_q;
        timeout_s = waiting_s && !mem_ack && (tmo_q == TMO_LAST);
        ack_s     = waiting_s && (mem_ack || timeout_s);
        rd_data_s = mem_ack ? mem_din : 8'hFF;
`ifdef MEM_ARB_ROM_WP_EN
        rom_wp_s  = cpu_we_lat_q & cpu_addr_lat_q[22];
`else
        rom_wp_s  = 1'b0;
`endif

        if (waiting_s) begin
            tmo_d = ack_s ? 8'd0 : tmo_q + 8'd1;
        end else begin
            tmo_d = tmo_q;
        end
        if (timeout_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                if (pend_vid_q) begin
                    state_d    = VID_LO;
                    mem_addr_d = {8'h00, vid_addr_lat_q, 1'b0};
                    mem_oe_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    tmo_d      = 8'd0;
                end else if (pend_cpu_q) begin
                    state_d    = CPU_ACC;
                    mem_addr_d = cpu_addr_lat_q;
                    mem_dout_d = cpu_dat_lat_q;
                    mem_we_d   = cpu_we_lat_q & ~rom_wp_s;
                    mem_oe_d   = ~cpu_we_lat_q;
                    tmo_d      = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                // No request outstanding here means a suppressed ROM write: complete at once.
                if (!waiting_s) begin
                    cpu_done_d = 1'b1;
                    cpu_clr_s  = 1'b1;
                    state_d    = IDLE;
                end else if (ack_s) begin
                    if (!mem_we_q) begin
                        cpu_din_d = rd_data_s;
                    end else begin
                        cpu_din_d = cpu_din_q;
                    end
                    mem_oe_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    cpu_done_d = 1'b1;
                    cpu_clr_s  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = CPU_ACC;
                end
            end
            VID_LO: begin
                if (ack_s) begin
                    vid_data_d[7:0] = rd_data_s;
                    mem_addr_d[0]   = 1'b1;
                    mem_oe_d        = 1'b0;
                    state_d         = VID_HI;
                end else begin
                    state_d = VID_LO;
                end
            end
            VID_HI: begin
                if (!waiting_s) begin
                    mem_oe_d = 1'b1;
                    tmo_d    = 8'd0;
                end else if (ack_s) begin
                    vid_data_d[15:8] = rd_data_s;
                    mem_oe_d         = 1'b0;
                    vid_done_d       = 1'b1;
                    vid_clr_s        = 1'b1;
                    state_d          = IDLE;
                end else begin
                    state_d = VID_HI;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_oe_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        // A request landing on the same edge as its source's completion is accepted.
        if (cpu_req) begin
            if (pend_cpu_q && !cpu_clr_s) begin
                err_d = 1'b1;
            end else begin
                pend_cpu_d     = 1'b1;
                cpu_we_lat_d   = cpu_we;
                cpu_addr_lat_d = cpu_addr;
                cpu_dat_lat_d  = cpu_dout;
            end
        end else if (cpu_clr_s) begin
            pend_cpu_d = 1'b0;
        end else begin
            pend_cpu_d = pend_cpu_q;
        end

        if (vid_req) begin
            if (pend_vid_q && !vid_clr_s) begin
                err_d = 1'b1;
            end else begin
                pend_vid_d     = 1'b1;
                vid_addr_lat_d = vid_addr;
            end
        end else if (vid_clr_s) begin
            pend_vid_d = 1'b0;
        end else begin
            pend_vid_d = pend_vid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= IDLE;
            pend_cpu_q     <= 1'b0;
            pend_vid_q     <= 1'b0;
            cpu_we_lat_q   <= 1'b0;
            cpu_addr_lat_q <= 23'd0;
            cpu_dat_lat_q  <= 8'd0;
            vid_addr_lat_q <= 15'd0;
            tmo_q          <= 8'd0;
            cpu_din_q      <= 8'd0;
            cpu_done_q     <= 1'b0;
            vid_done_q     <= 1'b0;
            vid_data_q     <= 16'd0;
            mem_addr_q     <= 23'd0;
            mem_dout_q     <= 8'd0;
            mem_oe_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_cpu_q     <= pend_cpu_d;
            pend_vid_q     <= pend_vid_d;
            cpu_we_lat_q   <= cpu_we_lat_d;
            cpu_addr_lat_q <= cpu_addr_lat_d;
            cpu_dat_lat_q  <= cpu_dat_lat_d;
            vid_addr_lat_q <= vid_addr_lat_d;
            tmo_q          <= tmo_d;
            cpu_din_q      <= cpu_din_d;
            cpu_done_q     <= cpu_done_d;
            vid_done_q     <= vid_done_d;
            vid_data_q     <= vid_data_d;
            mem_addr_q     <= mem_addr_d;
            mem_dout_q     <= mem_dout_d;
            mem_oe_q       <= mem_oe_d;
            mem_we_q       <= mem_we_d;
            err_q          <= err_d;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign cpu_done = cpu_done_q;
    assign vid_data = vid_data_q;
    assign vid_done = vid_done_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign mem_oe   = mem_oe_q;
    assign mem_we   = mem_we_q;
    assign err      = err_q;
endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed bench for amstrad_mem_arbiter: CPU transaction table plus hand-written sequences.
module tb_amstrad_mem_arbiter;
    logic        CLK = 1'b0;
    logic        reset, cpu_req, cpu_we, cpu_done, vid_req, vid_done;
    logic [22:0] cpu_addr, mem_addr;
    logic [7:0]  cpu_dout, cpu_din, mem_dout, mem_din;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic        mem_oe, mem_we, mem_ack, err;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  wdata;
        int          dly;
        logic [7:0]  ack_data;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t vecs [6];

    amstrad_mem_arbiter #(.TIMEOUT(64)) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_done(cpu_done),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_done(vid_done),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_din(mem_din), .mem_ack(mem_ack), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " cpu_din"}, 32'(cpu_din), 32'd0);
        chk({nm, " cpu_done"}, 32'(cpu_done), 32'd0);
        chk({nm, " vid_data"}, 32'(vid_data), 32'd0);
        chk({nm, " vid_done"}, 32'(vid_done), 32'd0);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, " mem_dout"}, 32'(mem_dout), 32'd0);
        chk({nm, " mem_oe"}, 32'(mem_oe), 32'd0);
        chk({nm, " mem_we"}, 32'(mem_we), 32'd0);
        chk({nm, " err"}, 32'(err), 32'd0);
    endtask

    task automatic cpu_xact(input logic we, input logic [22:0] a, input logic [7:0] wd,
                            input int dly, input logic [7:0] ad, input logic [7:0] exp_din);
        int held;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_dout = wd;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 23'd0; cpu_dout = 8'd0;
        chk("cpu no issue at N+1", 32'(mem_oe | mem_we), 32'd0);
        tick();
        chk("cpu mem_we", 32'(mem_we), 32'(we));
        chk("cpu mem_oe", 32'(mem_oe), 32'(!we));
        chk("cpu mem_addr", 32'(mem_addr), 32'(a));
        if (we) chk("cpu mem_dout", 32'(mem_dout), 32'(wd));
        held = 0;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (mem_oe | mem_we) held++;
        end
        chk("cpu req held", 32'(held), 32'(dly));
        mem_ack = 1'b1; mem_din = ad;
        tick();
        mem_ack = 1'b0; mem_din = 8'd0;
        chk("cpu req dropped", 32'(mem_oe | mem_we), 32'd0);
        chk("cpu_done", 32'(cpu_done), 32'd1);
        chk("cpu_din", 32'(cpu_din), 32'(exp_din));
        tick();
        chk("cpu_done pulse", 32'(cpu_done), 32'd0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{1'b0, 23'h000123, 8'h00, 3, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 23'h000010, 8'hAB, 0, 8'h00, 8'h5A};
        vecs[2] = '{1'b0, 23'h7FFFFF, 8'h00, 1, 8'hC3, 8'hC3};
        vecs[3] = '{1'b0, 23'h400000, 8'h00, 0, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 23'h0ABCDE, 8'h00, 2, 8'h99, 8'h00};
        vecs[5] = '{1'b0, 23'h000001, 8'h00, 5, 8'h3C, 8'h3C};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 23'd0; cpu_dout = 8'd0;
        vid_req = 1'b0; vid_addr = 15'd0; mem_din = 8'd0; mem_ack = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            cpu_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dly,
                     vecs[i].ack_data, vecs[i].exp_din);
        end

        // Video word fetch with a one-cycle gap between the two byte requests.
        vid_req = 1'b1; vid_addr = 15'h2000;
        tick();
        vid_req = 1'b0; vid_addr = 15'd0;
        tick();
        chk("vid lo oe", 32'(mem_oe), 32'd1);
        chk("vid lo addr", 32'(mem_addr), 32'h004000);
        tick();
        mem_ack = 1'b1; mem_din = 8'h11;
        tick();
        mem_ack = 1'b0;
        chk("vid gap oe", 32'(mem_oe), 32'd0);
        chk("vid hi addr", 32'(mem_addr), 32'h004001);
        tick();
        chk("vid hi oe", 32'(mem_oe), 32'd1);
        mem_ack = 1'b1; mem_din = 8'h22;
        tick();
        mem_ack = 1'b0;
        chk("vid_done", 32'(vid_done), 32'd1);
        chk("vid_data", 32'(vid_data), 32'h2211);
        tick();
        chk("vid_done pulse", 32'(vid_done), 32'd0);
        chk("vid idle oe", 32'(mem_oe), 32'd0);

        // Simultaneous CPU write and video fetch: video first.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000010; cpu_dout = 8'hAB;
        vid_req = 1'b1; vid_addr = 15'h2000;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 23'd0; cpu_dout = 8'd0;
        vid_req = 1'b0; vid_addr = 15'd0;
        tick();
        chk("sim vid first oe", 32'(mem_oe), 32'd1);
        chk("sim vid first we", 32'(mem_we), 32'd0);
        chk("sim vid addr", 32'(mem_addr), 32'h004000);
        mem_ack = 1'b1; mem_din = 8'h11;
        tick();
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1; mem_din = 8'h22;
        tick();
        mem_ack = 1'b0;
        chk("sim vid_done", 32'(vid_done), 32'd1);
        chk("sim vid_data", 32'(vid_data), 32'h2211);
        chk("sim cpu not yet", 32'(cpu_done | mem_we), 32'd0);
        tick();
        chk("sim cpu we", 32'(mem_we), 32'd1);
        chk("sim cpu addr", 32'(mem_addr), 32'h000010);
        chk("sim cpu dout", 32'(mem_dout), 32'h0000AB);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sim cpu_done", 32'(cpu_done), 32'd1);
        chk("sim err", 32'(err), 32'd0);
        tick();

`ifdef MEM_ARB_ROM_WP_EN
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h400000; cpu_dout = 8'h5C;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 23'd0;
        tick();
        chk("rom wp no req", 32'(mem_we | mem_oe), 32'd0);
        chk("rom wp early done", 32'(cpu_done), 32'd0);
        tick();
        chk("rom wp done", 32'(cpu_done), 32'd1);
        chk("rom wp we", 32'(mem_we), 32'd0);
        chk("rom wp err", 32'(err), 32'd0);
        tick();
`else
        cpu_xact(1'b1, 23'h400000, 8'h5C, 1, 8'h00, 8'h3C);
        chk("rom write err", 32'(err), 32'd0);
`endif

        // CPU read never acknowledged: forced completion after TIMEOUT cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200;
        tick();
        cpu_req = 1'b0; cpu_addr = 23'd0;
        tick();
        cnt = 0;
        while (mem_oe && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("timeout wait cycles", 32'(cnt), 32'd64);
        chk("timeout cpu_done", 32'(cpu_done), 32'd1);
        chk("timeout cpu_din", 32'(cpu_din), 32'h0000FF);
        chk("timeout err", 32'(err), 32'd1);
        tick();

        // Reset during VID_HI, then a stray late acknowledge.
        vid_req = 1'b1; vid_addr = 15'h1234;
        tick();
        vid_req = 1'b0; vid_addr = 15'd0;
        tick();
        chk("rst vid addr", 32'(mem_addr), 32'h002468);
        mem_ack = 1'b1; mem_din = 8'hAA;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rst in vid_hi oe", 32'(mem_oe), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("mid reset");
        mem_ack = 1'b1; mem_din = 8'h77;
        tick();
        mem_ack = 1'b0; mem_din = 8'd0;
        chk("late ack vid_done", 32'(vid_done), 32'd0);
        chk("late ack vid_data", 32'(vid_data), 32'd0);
        tick();
        chk("late ack idle", 32'(mem_oe | mem_we | vid_done), 32'd0);
        cpu_xact(1'b0, 23'h000042, 8'h00, 2, 8'hE7, 8'hE7);

        // Second cpu_req while the first is still pending raises err.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000005;
        tick();
        chk("ovf err clear", 32'(err), 32'd0);
        tick();
        cpu_req = 1'b0;
        chk("ovf err", 32'(err), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
